// File: rtl/multicycle_control_if.sv
// Bundles the controller's opcode/flag inputs and its datapath control strobes.
// The master side is the controller; the slave side is the datapath.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       exception;
    logic       instr_retired;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, exception, instr_retired, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, exception, instr_retired, state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS main controller: steps each instruction through fetch/decode/execute/memory/writeback
// over a shared memory port, with a memory-wait timeout and an illegal-opcode trap.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic             inWait;
    logic             timedOut;
    logic             unused_zero;

    // The branch decision itself is made in the datapath via pc_write_cond.
    assign unused_zero = bus.zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // The wait counter only runs while a memory access is stalled; any other cycle leaves it cleared.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = '0;
        inWait    = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
        timedOut  = inWait && !bus.mem_ready && (waitCnt_q == CNT_W'(MEM_TIMEOUT - 1));
        if (inWait && !bus.mem_ready && !timedOut) begin
            waitCnt_d = waitCnt_q + CNT_W'(1);
        end
        case (state_q)
            FETCH: begin
                if (bus.mem_ready)  state_d = DECODE;
                else if (timedOut)  state_d = TRAP;
            end
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:        state_d = R_EXEC;
                    OP_LW, OP_SW:    state_d = MEM_ADDR;
                    OP_BEQ:          state_d = BRANCH;
                    OP_J:            state_d = JUMP;
                    OP_ADDI, OP_SLTI: state_d = I_EXEC;
                    default:         state_d = TRAP;
                endcase
            end
            MEM_ADDR: begin
                if (bus.opcode == OP_LW)      state_d = MEM_RD;
                else if (bus.opcode == OP_SW) state_d = MEM_WR;
                else                          state_d = TRAP;
            end
            MEM_RD: begin
                if (bus.mem_ready)  state_d = MEM_WB;
                else if (timedOut)  state_d = TRAP;
            end
            MEM_WR: begin
                if (bus.mem_ready)  state_d = FETCH;
                else if (timedOut)  state_d = TRAP;
            end
            R_EXEC: state_d = R_WB;
            I_EXEC: state_d = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP, TRAP: state_d = FETCH;
            default: state_d = TRAP;
        endcase
    end

    // Outputs are forced low while reset is held so no strobe survives into reset.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.exception     = 1'b0;
        bus.instr_retired = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write  = 1'b1;
                        bus.pc_write  = 1'b1;
                        bus.alu_src_b = 2'b01;
                    end
                end
                DECODE: bus.alu_src_b = 2'b11;
                MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    bus.reg_write     = 1'b1;
                    bus.mem_to_reg    = 1'b1;
                    bus.instr_retired = 1'b1;
                end
                MEM_WR: begin
                    bus.mem_write     = 1'b1;
                    bus.i_or_d        = 1'b1;
                    bus.instr_retired = bus.mem_ready;
                end
                R_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                end
                R_WB: begin
                    bus.reg_write     = 1'b1;
                    bus.reg_dst       = 1'b1;
                    bus.instr_retired = 1'b1;
                end
                BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = 2'b01;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'b01;
                    bus.instr_retired = 1'b1;
                end
                JUMP: begin
                    bus.pc_write      = 1'b1;
                    bus.pc_source     = 2'b10;
                    bus.instr_retired = 1'b1;
                end
                I_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.alu_op    = (bus.opcode == OP_SLTI) ? 2'b11 : 2'b00;
                end
                I_WB: begin
                    bus.reg_write     = 1'b1;
                    bus.instr_retired = 1'b1;
                end
                TRAP: begin
                    bus.exception = 1'b1;
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'b11;
                end
                default: ;
            endcase
        end
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for the multi-cycle controller: each instruction is expanded into its expected
// per-cycle state/strobe trace from the instruction class and memory stall lengths, then compared.
module tb_multicycle_control_fsm;

    localparam int TIMEOUT = 16;
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MADDR = 4'd2, S_MRD = 4'd3,
                           S_MWB = 4'd4, S_MWR = 4'd5, S_REX = 4'd6, S_RWB = 4'd7,
                           S_BR = 4'd8, S_JMP = 4'd9, S_IEX = 4'd10, S_IWB = 4'd11, S_TRAP = 4'd12;
    localparam logic [5:0] OP_R = 6'd0, OP_LW = 6'd35, OP_SW = 6'd43, OP_BEQ = 6'd4,
                           OP_J = 6'd2, OP_ADDI = 6'd8, OP_SLTI = 6'd10;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic       ret;
        logic [5:0] op;
        logic       z;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   evaluated = 0;
    int   failures = 0;

    cyc_t        expQ[$];
    logic [3:0]  obsSt[$];
    logic [16:0] obsOut[$];
    logic        obsRet[$];

    multicycle_control_if bus();

    multicycle_control_fsm #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Control vector {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
    // reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, exception} expected for one cycle.
    function automatic logic [16:0] expOut(cyc_t e);
        logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, ex = 0;
        logic [1:0] sb = 0, op = 0, ps = 0;
        case (e.st)
            S_FETCH: begin mr = 1; if (e.rdy) begin irw = 1; pw = 1; sb = 2'b01; end end
            S_DECODE: sb = 2'b11;
            S_MADDR: begin sa = 1; sb = 2'b10; end
            S_MRD: begin mr = 1; iod = 1; end
            S_MWB: begin rw = 1; m2r = 1; end
            S_MWR: begin mw = 1; iod = 1; end
            S_REX: begin sa = 1; op = 2'b10; end
            S_RWB: begin rw = 1; rd = 1; end
            S_BR: begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            S_JMP: begin pw = 1; ps = 2'b10; end
            S_IEX: begin sa = 1; sb = 2'b10; op = (e.op == OP_SLTI) ? 2'b11 : 2'b00; end
            S_IWB: rw = 1;
            S_TRAP: begin ex = 1; pw = 1; ps = 2'b11; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, ex};
    endfunction

    function automatic void pushCyc(logic [3:0] st, logic rdy, logic [5:0] op, logic z);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.ret = 1'b0; c.op = op; c.z = z;
        expQ.push_back(c);
    endfunction

    // A memory phase stalled w cycles; returns 1 when the stall is long enough to trap.
    function automatic bit pushWait(logic [3:0] st, int w, logic [5:0] op, logic z);
        if (w >= TIMEOUT) begin
            for (int k = 0; k < TIMEOUT; k++) pushCyc(st, 1'b0, op, z);
            pushCyc(S_TRAP, 1'b0, op, z);
            return 1'b1;
        end
        for (int k = 0; k < w; k++) pushCyc(st, 1'b0, op, z);
        pushCyc(st, 1'b1, op, z);
        return 1'b0;
    endfunction

    function automatic void buildInstr(logic [5:0] op, logic z, int fw, int mw);
        if (pushWait(S_FETCH, fw, op, z)) return;
        pushCyc(S_DECODE, 1'b0, op, z);
        case (op)
            OP_R: begin pushCyc(S_REX, 0, op, z); pushCyc(S_RWB, 0, op, z); end
            OP_LW: begin
                pushCyc(S_MADDR, 0, op, z);
                if (pushWait(S_MRD, mw, op, z)) return;
                pushCyc(S_MWB, 0, op, z);
            end
            OP_SW: begin
                pushCyc(S_MADDR, 0, op, z);
                if (pushWait(S_MWR, mw, op, z)) return;
            end
            OP_BEQ: pushCyc(S_BR, 0, op, z);
            OP_J: pushCyc(S_JMP, 0, op, z);
            OP_ADDI, OP_SLTI: begin pushCyc(S_IEX, 0, op, z); pushCyc(S_IWB, 0, op, z); end
            default: begin pushCyc(S_TRAP, 0, op, z); return; end
        endcase
        expQ[expQ.size() - 1].ret = 1'b1;
    endfunction

    function automatic void clearAll();
        expQ.delete(); obsSt.delete(); obsOut.delete(); obsRet.delete();
    endfunction

    // Plays the expected trace's inputs one cycle at a time and records what the DUT shows.
    task automatic applyStimulus();
        foreach (expQ[i]) begin
            bus.mem_ready = expQ[i].rdy;
            bus.opcode    = expQ[i].op;
            bus.zero      = expQ[i].z;
            #1;
            obsSt.push_back(bus.state);
            obsOut.push_back({bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                              bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                              bus.alu_src_b, bus.alu_op, bus.pc_source, bus.exception});
            obsRet.push_back(bus.instr_retired);
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        evaluated++;
        if ({bus.state, bus.mem_read, bus.pc_write, bus.exception, bus.instr_retired} !== 8'h0) begin
            failures++;
            $display("[TB] FAIL reset_hold: got state=%0d mem_read=%b, expected state=0 all outputs 0",
                     bus.state, bus.mem_read);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        evaluated++;
        if ({bus.state, bus.mem_read} !== {S_FETCH, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_release: got state=%0d mem_read=%b, expected state=0 mem_read=1",
                     bus.state, bus.mem_read);
        end
    endtask

    task automatic test_rtype();
        clearAll();
        buildInstr(OP_R, 1'b0, 0, 0);
        buildInstr(OP_ADDI, 1'b0, 0, 0);
        buildInstr(OP_SLTI, 1'b1, 1, 0);
        buildInstr(OP_J, 1'b0, 0, 0);
        applyStimulus();
        for (int i = 0; i < expQ.size(); i++) begin
            evaluated++;
            if ({obsSt[i], obsOut[i], obsRet[i]} !== {expQ[i].st, expOut(expQ[i]), expQ[i].ret}) begin
                failures++;
                $display("[TB] FAIL rtype cyc%0d: got st=%0d ctl=%h ret=%b, expected st=%0d ctl=%h ret=%b",
                         i, obsSt[i], obsOut[i], obsRet[i], expQ[i].st, expOut(expQ[i]), expQ[i].ret);
            end
        end
    endtask

    task automatic test_lw_stall();
        clearAll();
        buildInstr(OP_LW, 1'b0, 0, 3);
        buildInstr(OP_SW, 1'b0, 0, 0);
        buildInstr(OP_SW, 1'b0, 2, 2);
        applyStimulus();
        for (int i = 0; i < expQ.size(); i++) begin
            evaluated++;
            if ({obsSt[i], obsOut[i], obsRet[i]} !== {expQ[i].st, expOut(expQ[i]), expQ[i].ret}) begin
                failures++;
                $display("[TB] FAIL lw_stall cyc%0d: got st=%0d ctl=%h ret=%b, expected st=%0d ctl=%h ret=%b",
                         i, obsSt[i], obsOut[i], obsRet[i], expQ[i].st, expOut(expQ[i]), expQ[i].ret);
            end
        end
    endtask

    task automatic test_beq();
        clearAll();
        buildInstr(OP_BEQ, 1'b1, 0, 0);
        buildInstr(OP_BEQ, 1'b0, 0, 0);
        applyStimulus();
        for (int i = 0; i < expQ.size(); i++) begin
            evaluated++;
            if ({obsSt[i], obsOut[i], obsRet[i]} !== {expQ[i].st, expOut(expQ[i]), expQ[i].ret}) begin
                failures++;
                $display("[TB] FAIL beq cyc%0d: got st=%0d ctl=%h ret=%b, expected st=%0d ctl=%h ret=%b",
                         i, obsSt[i], obsOut[i], obsRet[i], expQ[i].st, expOut(expQ[i]), expQ[i].ret);
            end
        end
    endtask

    task automatic test_illegal();
        clearAll();
        buildInstr(6'b111111, 1'b0, 0, 0);
        buildInstr(6'b000001, 1'b0, 0, 0);
        applyStimulus();
        for (int i = 0; i < expQ.size(); i++) begin
            evaluated++;
            if ({obsSt[i], obsOut[i], obsRet[i]} !== {expQ[i].st, expOut(expQ[i]), expQ[i].ret}) begin
                failures++;
                $display("[TB] FAIL illegal cyc%0d: got st=%0d ctl=%h ret=%b, expected st=%0d ctl=%h ret=%b",
                         i, obsSt[i], obsOut[i], obsRet[i], expQ[i].st, expOut(expQ[i]), expQ[i].ret);
            end
        end
    endtask

    task automatic test_timeout();
        clearAll();
        buildInstr(OP_R, 1'b0, TIMEOUT, 0);
        buildInstr(OP_R, 1'b0, TIMEOUT - 1, 0);
        buildInstr(OP_LW, 1'b0, 0, TIMEOUT);
        buildInstr(OP_SW, 1'b0, 0, TIMEOUT);
        buildInstr(OP_SW, 1'b0, 0, TIMEOUT - 1);
        applyStimulus();
        for (int i = 0; i < expQ.size(); i++) begin
            evaluated++;
            if ({obsSt[i], obsOut[i], obsRet[i]} !== {expQ[i].st, expOut(expQ[i]), expQ[i].ret}) begin
                failures++;
                $display("[TB] FAIL timeout cyc%0d: got st=%0d ctl=%h ret=%b, expected st=%0d ctl=%h ret=%b",
                         i, obsSt[i], obsOut[i], obsRet[i], expQ[i].st, expOut(expQ[i]), expQ[i].ret);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] legal[7];
        logic [5:0] op;
        int fw, mw;
        legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI};
        clearAll();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom_range(0, 63));
            end else begin
                op = legal[$urandom_range(0, 6)];
            end
            fw = ($urandom_range(0, 19) == 0) ? TIMEOUT : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, 4));
            buildInstr(op, 1'($urandom_range(0, 1)), fw, mw);
        end
        applyStimulus();
        for (int i = 0; i < expQ.size(); i++) begin
            evaluated++;
            if ({obsSt[i], obsOut[i], obsRet[i]} !== {expQ[i].st, expOut(expQ[i]), expQ[i].ret}) begin
                failures++;
                $display("[TB] FAIL random cyc%0d: got st=%0d ctl=%h ret=%b, expected st=%0d ctl=%h ret=%b",
                         i, obsSt[i], obsOut[i], obsRet[i], expQ[i].st, expOut(expQ[i]), expQ[i].ret);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        clearAll();
        pushCyc(S_FETCH, 1'b1, OP_SW, 1'b0);
        pushCyc(S_DECODE, 1'b0, OP_SW, 1'b0);
        pushCyc(S_MADDR, 1'b0, OP_SW, 1'b0);
        pushCyc(S_MWR, 1'b0, OP_SW, 1'b0);
        pushCyc(S_MWR, 1'b0, OP_SW, 1'b0);
        applyStimulus();
        for (int i = 0; i < expQ.size(); i++) begin
            evaluated++;
            if ({obsSt[i], obsOut[i], obsRet[i]} !== {expQ[i].st, expOut(expQ[i]), expQ[i].ret}) begin
                failures++;
                $display("[TB] FAIL mid_write cyc%0d: got st=%0d ctl=%h ret=%b, expected st=%0d ctl=%h ret=%b",
                         i, obsSt[i], obsOut[i], obsRet[i], expQ[i].st, expOut(expQ[i]), expQ[i].ret);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        evaluated++;
        if ({bus.state, bus.mem_write, bus.i_or_d, bus.mem_read} !== 7'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid_write: got state=%0d mem_write=%b, expected state=0 mem_write=0",
                     bus.state, bus.mem_write);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        evaluated++;
        if ({bus.state, bus.mem_read, bus.mem_write} !== {S_FETCH, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL refetch: got state=%0d mem_read=%b, expected state=0 mem_read=1",
                     bus.state, bus.mem_read);
        end
    endtask

    initial begin
        bus.opcode    = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
